// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage and its store buffer.
// FSM states, store-buffer entry layout and default widths.
package mem_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_REG_W    = 4;
  localparam int DEF_SB_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_WAIT  = 2'd1,
    ST_DRAIN_WAIT = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer.sv
// Circular FIFO of pending stores with a youngest-match forward lookup.
// Entry validity is derived from the occupancy count, not per-entry bits.
module mem_store_buffer
  import mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SB_DEPTH = DEF_SB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] lkp_addr_i,
  output logic              lkp_hit_o,
  output logic [DATA_W-1:0] lkp_data_o,
  output logic [DATA_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t             ent_q [SB_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [PTR_W-1:0] idx;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        ent_q[wr_ptr_q] <= '{addr: push_addr_i, data: push_data_i};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  // Walk oldest to youngest so the last match seen wins.
  always_comb begin
    lkp_hit_o  = 1'b0;
    lkp_data_o = '0;
    idx        = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < cnt_q) &&
          (ent_q[idx].addr == lkp_addr_i)) begin
        lkp_hit_o  = 1'b1;
        lkp_data_o = ent_q[idx].data;
      end
    end
  end

  assign head_addr_o = ent_q[rd_ptr_q].addr;
  assign head_data_o = ent_q[rd_ptr_q].data;
  assign full_o      = (cnt_q == CNT_W'(SB_DEPTH));
  assign empty_o     = (cnt_q == '0);

endmodule

// File: rtl/mem_stage_sb.sv
// Memory-access stage: load/store FSM over a req/ack port, store buffer
// with forwarding, and the MEM/WB pipeline register with freeze.
module mem_stage_sb
  import mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_W    = DEF_REG_W,
  parameter int SB_DEPTH = DEF_SB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              wb_en,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [REG_W-1:0]  dest,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] val_rm,
  output logic              mem_ready,
  output logic              sb_empty,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en_out,
  output logic              mem_read_out,
  output logic [REG_W-1:0]  dest_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] mem_data_out
);

  mem_state_e        state_q;
  mem_state_e        state_d;
  logic              req_q;
  logic              req_d;
  logic              we_q;
  logic              we_d;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_d;

  logic              wb_en_q;
  logic              mem_read_q;
  logic [REG_W-1:0]  dest_q;
  logic [DATA_W-1:0] alu_res_q;
  logic [DATA_W-1:0] mem_data_q;

  logic              is_ld;
  logic              is_st;
  logic              ld_wait;
  logic              ld_miss;
  logic              sb_push;
  logic              sb_pop;
  logic              sb_hit;
  logic              sb_full;
  logic              sb_emp;
  logic [DATA_W-1:0] sb_fwd;
  logic [DATA_W-1:0] sb_head_addr;
  logic [DATA_W-1:0] sb_head_data;
  logic [DATA_W-1:0] ld_data;

  assign is_ld   = mem_read;
  assign is_st   = mem_write & ~mem_read;
  assign ld_wait = (state_q == ST_LOAD_WAIT);
  assign ld_miss = is_ld & ~sb_hit;
  assign sb_pop  = (state_q == ST_DRAIN_WAIT) & mem_ack;
  assign ld_data = ld_wait ? mem_rdata : sb_fwd;

  always_comb begin
    mem_ready = 1'b1;
    unique case (1'b1)
      is_ld:   mem_ready = ld_wait ? mem_ack : sb_hit;
      is_st:   mem_ready = ~sb_full | sb_pop;
      default: mem_ready = 1'b1;
    endcase
  end

  // A frozen store is re-presented next cycle, so it must not enqueue now.
  assign sb_push = is_st & mem_ready & ~freeze;

  mem_store_buffer #(
    .DATA_W   (DATA_W),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .push_i      (sb_push),
    .push_addr_i (alu_res),
    .push_data_i (val_rm),
    .pop_i       (sb_pop),
    .lkp_addr_i  (alu_res),
    .lkp_hit_o   (sb_hit),
    .lkp_data_o  (sb_fwd),
    .head_addr_o (sb_head_addr),
    .head_data_o (sb_head_data),
    .full_o      (sb_full),
    .empty_o     (sb_emp)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_miss) begin
          state_d = ST_LOAD_WAIT;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = alu_res;
        end else if (!sb_emp) begin
          state_d = ST_DRAIN_WAIT;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = sb_head_addr;
          wdata_d = sb_head_data;
        end
      end
      ST_LOAD_WAIT: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      ST_DRAIN_WAIT: begin
        if (mem_ack) begin
          if (ld_miss) begin
            state_d = ST_LOAD_WAIT;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = alu_res;
          end else begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Stall inserts a bubble; payload fields simply hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_read_q <= 1'b0;
      dest_q     <= '0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
    end else if (!freeze) begin
      if (mem_ready) begin
        wb_en_q    <= wb_en;
        mem_read_q <= is_ld;
        dest_q     <= dest;
        alu_res_q  <= alu_res;
        mem_data_q <= is_ld ? ld_data : '0;
      end else begin
        wb_en_q    <= 1'b0;
        mem_read_q <= 1'b0;
      end
    end
  end

  assign sb_empty     = sb_emp;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign wb_en_out    = wb_en_q;
  assign mem_read_out = mem_read_q;
  assign dest_out     = dest_q;
  assign alu_res_out  = alu_res_q;
  assign mem_data_out = mem_data_q;

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: queue-level reference model checked
// every cycle, plus literal expectations at key points.
module tb_mem_stage_sb;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          freeze = 1'b0;
  logic          wb_en = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [RW-1:0] dest = '0;
  logic [DW-1:0] alu_res = '0;
  logic [DW-1:0] val_rm = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  logic          mem_ready;
  logic          sb_empty;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          wb_en_out;
  logic          mem_read_out;
  logic [RW-1:0] dest_out;
  logic [DW-1:0] alu_res_out;
  logic [DW-1:0] mem_data_out;

  always #5 clk = ~clk;

  mem_stage_sb #(
    .DATA_W   (DW),
    .REG_W    (RW),
    .SB_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .wb_en        (wb_en),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .dest         (dest),
    .alu_res      (alu_res),
    .val_rm       (val_rm),
    .mem_ready    (mem_ready),
    .sb_empty     (sb_empty),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .wb_en_out    (wb_en_out),
    .mem_read_out (mem_read_out),
    .dest_out     (dest_out),
    .alu_res_out  (alu_res_out),
    .mem_data_out (mem_data_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending stores as a queue, one outstanding access.
  logic [DW-1:0] mq_a[$];
  logic [DW-1:0] mq_d[$];
  int            m_pend;
  logic [DW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_wb;
  logic          m_rd;
  logic [RW-1:0] m_dest;
  logic [DW-1:0] m_alu;
  logic [DW-1:0] m_mdata;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit f_hit(input logic [DW-1:0] a);
    foreach (mq_a[i]) if (mq_a[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] f_data(input logic [DW-1:0] a);
    logic [DW-1:0] r = '0;
    foreach (mq_a[i]) if (mq_a[i] == a) r = mq_d[i];
    return r;
  endfunction

  function automatic bit m_ready_f();
    if (mem_read) return (m_pend == 1) ? mem_ack : f_hit(alu_res);
    if (mem_write) return (mq_a.size() < D) || (m_pend == 2 && mem_ack);
    return 1'b1;
  endfunction

  task automatic m_clear();
    mq_a.delete();
    mq_d.delete();
    m_pend  = 0;
    m_addr  = '0;
    m_wdata = '0;
    m_wb    = 1'b0;
    m_rd    = 1'b0;
    m_dest  = '0;
    m_alu   = '0;
    m_mdata = '0;
  endtask

  task automatic m_step();
    bit rdy, hit, ld, st, pop;
    logic [DW-1:0] ldv;
    ld  = mem_read;
    st  = mem_write && !mem_read;
    rdy = m_ready_f();
    hit = f_hit(alu_res);
    pop = (m_pend == 2) && mem_ack;
    ldv = (m_pend == 1) ? mem_rdata : f_data(alu_res);
    if (!freeze) begin
      if (rdy) begin
        m_wb = wb_en; m_rd = ld; m_dest = dest; m_alu = alu_res;
        m_mdata = ld ? ldv : '0;
      end else begin
        m_wb = 1'b0; m_rd = 1'b0;
      end
    end
    if (m_pend == 0) begin
      if (ld && !hit) begin
        m_pend = 1; m_addr = alu_res;
      end else if (mq_a.size() > 0) begin
        m_pend = 2; m_addr = mq_a[0]; m_wdata = mq_d[0];
      end
    end else if (mem_ack) begin
      if (m_pend == 2 && ld && !hit) begin
        m_pend = 1; m_addr = alu_res;
      end else begin
        m_pend = 0;
      end
    end
    if (pop) begin
      void'(mq_a.pop_front());
      void'(mq_d.pop_front());
    end
    if (st && !freeze && rdy) begin
      mq_a.push_back(alu_res);
      mq_d.push_back(val_rm);
    end
  endtask

  task automatic compare();
    chk("mem_ready", mem_ready, m_ready_f());
    chk("sb_empty", sb_empty, mq_a.size() == 0);
    chk("mem_req", mem_req, m_pend != 0);
    if (m_pend != 0) begin
      chk("mem_we", mem_we, m_pend == 2);
      chk("mem_addr", mem_addr, m_addr);
      if (m_pend == 2) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("wb_en_out", wb_en_out, m_wb);
    chk("mem_read_out", mem_read_out, m_rd);
    chk("dest_out", dest_out, m_dest);
    chk("alu_res_out", alu_res_out, m_alu);
    if (m_rd) chk("mem_data_out", mem_data_out, m_mdata);
  endtask

  task automatic cyc(input logic ack, input logic [DW-1:0] rd);
    mem_ack   = ack;
    mem_rdata = rd;
    @(negedge clk);
    compare();
    @(posedge clk);
    if (!rst) m_clear();
    else m_step();
    #1;
    mem_ack = 1'b0;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic wbe,
                        input logic [RW-1:0] d, input logic [DW-1:0] a,
                        input logic [DW-1:0] v);
    mem_read = rd; mem_write = wr; wb_en = wbe;
    dest = d; alu_res = a; val_rm = v;
  endtask

  task automatic idle();
    set_op(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (mq_a.size() != 0 || m_pend != 0); i++)
      cyc(m_pend != 0, 32'h0);
    chk("drain_empty", sb_empty, 1'b1);
    chk("drain_noreq", mem_req, 1'b0);
  endtask

  int lows;

  initial begin
    m_clear();
    // Reset state
    cyc(1'b0, '0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_sbe", sb_empty, 1'b1);
    chk("rst_wbout", wb_en_out, 1'b0);
    rst = 1'b1;
    cyc(1'b0, '0);
    #2 chk("post_rst_ready", mem_ready, 1'b1);

    // Store then load same address: forward, no load request
    set_op(1'b0, 1'b1, 1'b0, 4'd0, 32'h10, 32'hAAAA);
    cyc(1'b0, '0);
    set_op(1'b1, 1'b0, 1'b1, 4'd3, 32'h10, 32'h0);
    #2 chk("fwd_ready", mem_ready, 1'b1);
    chk("fwd_noreq", mem_req, 1'b0);
    cyc(1'b0, '0);
    chk("fwd_data", mem_data_out, 32'hAAAA);
    chk("fwd_req_is_drain", mem_we, 1'b1);
    idle();
    drain();

    // Two stores to the same address, drain held: youngest forwards
    set_op(1'b0, 1'b1, 1'b0, 4'd0, 32'h20, 32'h1);
    cyc(1'b0, '0);
    set_op(1'b0, 1'b1, 1'b0, 4'd0, 32'h20, 32'h2);
    cyc(1'b0, '0);
    set_op(1'b1, 1'b0, 1'b1, 4'd4, 32'h20, 32'h0);
    cyc(1'b0, '0);
    chk("youngest_fwd", mem_data_out, 32'h2);
    idle();
    drain();

    // Load miss, ack in the fourth cycle
    set_op(1'b0, 1'b0, 1'b1, 4'd1, 32'h5, 32'h0);
    cyc(1'b0, '0);
    set_op(1'b1, 1'b0, 1'b1, 4'd5, 32'h40, 32'h0);
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      #2 if (!mem_ready) lows++;
      if (i == 1 || i == 2) chk("miss_bubble", wb_en_out, 1'b0);
      cyc(i == 3, (i == 3) ? 32'hDEAD : 32'h0);
    end
    chk("miss_lows", lows, 3);
    chk("miss_data", mem_data_out, 32'hDEAD);
    chk("miss_wb", wb_en_out, 1'b1);
    chk("miss_dest", dest_out, 4'd5);

    // Load miss arriving while a drain is outstanding
    set_op(1'b0, 1'b1, 1'b0, 4'd0, 32'h50, 32'h7);
    cyc(1'b0, '0);
    idle();
    cyc(1'b0, '0);
    set_op(1'b1, 1'b0, 1'b1, 4'd6, 32'h60, 32'h0);
    cyc(1'b0, '0);
    cyc(1'b1, '0);
    chk("dmiss_req", mem_req, 1'b1);
    chk("dmiss_we", mem_we, 1'b0);
    chk("dmiss_addr", mem_addr, 32'h60);
    cyc(1'b1, 32'h1234);
    chk("dmiss_data", mem_data_out, 32'h1234);
    idle();
    drain();

    // Fill the buffer; fifth store stalls until a drain ack
    for (int i = 0; i < 4; i++) begin
      set_op(1'b0, 1'b1, 1'b0, 4'd0, 32'h100 + i, 32'hB0 + i);
      cyc(1'b0, '0);
    end
    set_op(1'b0, 1'b1, 1'b0, 4'd0, 32'h104, 32'hB4);
    #2 chk("full_stall0", mem_ready, 1'b0);
    cyc(1'b0, '0);
    #2 chk("full_stall1", mem_ready, 1'b0);
    cyc(1'b0, '0);
    mem_ack = 1'b1;
    #2 chk("full_ack_ready", mem_ready, 1'b1);
    cyc(1'b1, '0);
    set_op(1'b0, 1'b1, 1'b0, 4'd0, 32'h105, 32'hB5);
    #2 chk("still_full", mem_ready, 1'b0);
    cyc(1'b0, '0);
    cyc(1'b1, '0);
    idle();
    drain();

    // Freeze holds the MEM/WB register
    set_op(1'b0, 1'b0, 1'b1, 4'd7, 32'h77, 32'h0);
    cyc(1'b0, '0);
    chk("pass_alu", alu_res_out, 32'h77);
    set_op(1'b0, 1'b0, 1'b1, 4'd8, 32'h88, 32'h0);
    freeze = 1'b1;
    cyc(1'b0, '0);
    chk("frz_alu0", alu_res_out, 32'h77);
    cyc(1'b0, '0);
    chk("frz_alu1", alu_res_out, 32'h77);
    chk("frz_dest", dest_out, 4'd7);
    freeze = 1'b0;
    cyc(1'b0, '0);
    chk("unfrz_alu", alu_res_out, 32'h88);
    chk("unfrz_dest", dest_out, 4'd8);

    // Read and write together behave as a load
    set_op(1'b1, 1'b1, 1'b1, 4'd9, 32'h200, 32'h9);
    cyc(1'b0, '0);
    cyc(1'b1, 32'h55);
    chk("rdwr_data", mem_data_out, 32'h55);
    chk("rdwr_nostore", sb_empty, 1'b1);
    idle();
    cyc(1'b0, '0);

    // Asynchronous reset during an outstanding load
    set_op(1'b1, 1'b0, 1'b1, 4'd10, 32'h300, 32'h0);
    cyc(1'b0, '0);
    chk("pre_rst_req", mem_req, 1'b1);
    #2 rst = 1'b0;
    m_clear();
    #1;
    chk("arst_req", mem_req, 1'b0);
    chk("arst_wb", wb_en_out, 1'b0);
    chk("arst_alu", alu_res_out, 32'h0);
    chk("arst_sbe", sb_empty, 1'b1);
    idle();
    cyc(1'b1, 32'hBAD);
    rst = 1'b1;
    cyc(1'b1, 32'hBAD);
    chk("stray_req", mem_req, 1'b0);
    chk("stray_wb", wb_en_out, 1'b0);
    chk("stray_sbe", sb_empty, 1'b1);
    cyc(1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
